// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor: FSM encoding,
// output bundle decoding and the saturating lock-loss counter step.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABILIZE = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    localparam logic [7:0] LOST_MAX = 8'd255;

    typedef struct packed {
        logic pll_reset;
        logic clk_ok;
        logic fault;
    } outs_t;

    function automatic outs_t decode_outs(input state_t st);
        outs_t o;
        o = '0;
        case (st)
            ST_RESET:     o.pll_reset = 1'b1;
            ST_WAIT_LOCK: o.pll_reset = 1'b0;
            ST_STABILIZE: o.pll_reset = 1'b0;
            ST_RUN:       o.clk_ok    = 1'b1;
            ST_FAULT: begin
                o.pll_reset = 1'b1;
                o.fault     = 1'b1;
            end
            default:      o.pll_reset = 1'b1;
        endcase
        return o;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == LOST_MAX) ? LOST_MAX : v + 8'd1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for bringing asynchronous level signals into the
// local clock domain; reset clears both stages.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // metastability stage followed by the stable output stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= '0;
            sync_r <= '0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences the PLL reset, qualifies the asynchronous lock into clk_ok,
// retries failed lock attempts and latches a fault once retries run out.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 2500000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRY     = 3,
    parameter int CNT_W         = 22
) (
    input  logic       clkin,
    input  logic       resetn,
    input  logic       pll_lock,
    input  logic       relock_req,
    output logic       pll_reset,
    output logic       clk_ok,
    output logic       fault,
    output logic [7:0] lost_cnt,
    output logic [2:0] state
);

    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_DONE  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_MAX      = {CNT_W{1'b1}};
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);

    logic               lock_s;
    state_t             state_r;
    state_t             next_state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               restart_s;
    logic [RETRY_W-1:0] retry_r;
    logic [RETRY_W-1:0] retry_next_s;
    logic [RETRY_W-1:0] retry_inc_s;
    logic               lost_inc_s;
    logic [7:0]         lost_r;
    outs_t              outs_next_s;
    outs_t              outs_r;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk   (clkin),
        .rst_n (resetn),
        .d     (pll_lock),
        .q     (lock_s)
    );

    assign retry_inc_s = retry_r + RETRY_W'(1);

    // state register
    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_RESET;
        end else begin
            state_r <= next_state_s;
        end
    end

    // next-state, retry and lock-loss decisions; relock_req overrides everything
    always_comb begin
        next_state_s = state_r;
        retry_next_s = retry_r;
        lost_inc_s   = 1'b0;
        if (relock_req) begin
            next_state_s = ST_RESET;
            retry_next_s = '0;
        end else begin
            case (state_r)
                ST_RESET: begin
                    if (cnt_r == RST_LAST) begin
                        next_state_s = ST_WAIT_LOCK;
                    end else begin
                        next_state_s = ST_RESET;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        next_state_s = ST_STABILIZE;
                    end else if (cnt_r == TIMEOUT_LAST) begin
                        retry_next_s = retry_inc_s;
                        if (retry_inc_s == RETRY_LIMIT) begin
                            next_state_s = ST_FAULT;
                        end else begin
                            next_state_s = ST_RESET;
                        end
                    end else begin
                        next_state_s = ST_WAIT_LOCK;
                    end
                end
                ST_STABILIZE: begin
                    if (!lock_s) begin
                        next_state_s = ST_WAIT_LOCK;
                    end else if (cnt_r == STABLE_DONE) begin
                        next_state_s = ST_RUN;
                        retry_next_s = '0;
                    end else begin
                        next_state_s = ST_STABILIZE;
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        next_state_s = ST_RESET;
                        lost_inc_s   = 1'b1;
                    end else begin
                        next_state_s = ST_RUN;
                    end
                end
                ST_FAULT: next_state_s = ST_FAULT;
                default:  next_state_s = ST_RESET;
            endcase
        end
    end

    // output decode from the upcoming state so the output flops line up with state_r
    always_comb begin
        outs_next_s = decode_outs(next_state_s);
    end

    // any state entry, including a repeated relock request, restarts the shared counter
    assign restart_s = (next_state_s != state_r) || relock_req;

    // shared cycle counter, held at its maximum in the long-lived states
    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            cnt_r <= '0;
        end else if (restart_s) begin
            cnt_r <= '0;
        end else if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // retry bookkeeping and saturating lock-loss count
    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            retry_r <= '0;
            lost_r  <= 8'd0;
        end else begin
            retry_r <= retry_next_s;
            if (lost_inc_s) begin
                lost_r <= sat_inc8(lost_r);
            end else begin
                lost_r <= lost_r;
            end
        end
    end

    // registered outputs; reset holds the PLL in reset with clk_ok low
    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            outs_r <= '{pll_reset: 1'b1, clk_ok: 1'b0, fault: 1'b0};
        end else begin
            outs_r <= outs_next_s;
        end
    end

    assign pll_reset = outs_r.pll_reset;
    assign clk_ok    = outs_r.clk_ok;
    assign fault     = outs_r.fault;
    assign lost_cnt  = lost_r;
    assign state     = state_r;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with short cycle parameters;
// expected values are hand-derived cycle counts from the lock timing.
module tb_pll_lock_supervisor;

    logic       clkin;
    logic       resetn;
    logic       pll_lock;
    logic       relock_req;
    logic       pll_reset;
    logic       clk_ok;
    logic       fault;
    logic [7:0] lost_cnt;
    logic [2:0] state;

    int checks;
    int errors;
    int exp_lost;
    int hi_cnt;

    pll_lock_supervisor #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (20),
        .STABLE_CYCLES (8),
        .MAX_RETRY     (2),
        .CNT_W         (22)
    ) u_dut (
        .clkin      (clkin),
        .resetn     (resetn),
        .pll_lock   (pll_lock),
        .relock_req (relock_req),
        .pll_reset  (pll_reset),
        .clk_ok     (clk_ok),
        .fault      (fault),
        .lost_cnt   (lost_cnt),
        .state      (state)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    task automatic tick(input int n);
        repeat (n) @(posedge clkin);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks     = 0;
        errors     = 0;
        resetn     = 1'b0;
        pll_lock   = 1'b0;
        relock_req = 1'b0;
        tick(2);
        check("rst_pll_reset", 8'(pll_reset), 8'd1);
        check("rst_clk_ok", 8'(clk_ok), 8'd0);
        check("rst_fault", 8'(fault), 8'd0);
        check("rst_lost", lost_cnt, 8'd0);
        check("rst_state", 8'(state), 8'd0);

        // bring-up: reset pulse of 4 cycles, lock rises 10 cycles after release
        resetn = 1'b1;
        tick(3);
        check("bring_rst_hold", 8'(pll_reset), 8'd1);
        check("bring_state0", 8'(state), 8'd0);
        tick(1);
        check("bring_rst_drop", 8'(pll_reset), 8'd0);
        check("bring_wait", 8'(state), 8'd1);
        tick(6);
        pll_lock = 1'b1;
        tick(2);
        check("bring_sync_lat", 8'(state), 8'd1);
        tick(1);
        check("bring_stab", 8'(state), 8'd2);
        tick(8);
        check("bring_stab_end", 8'(state), 8'd2);
        check("bring_ok_low", 8'(clk_ok), 8'd0);
        tick(1);
        check("bring_ok_high", 8'(clk_ok), 8'd1);
        check("bring_run", 8'(state), 8'd3);
        check("bring_pll_rst", 8'(pll_reset), 8'd0);

        // relock request coinciding with a sampled lock drop in RUN
        pll_lock = 1'b0;
        tick(2);
        relock_req = 1'b1;
        tick(1);
        relock_req = 1'b0;
        check("coin_state", 8'(state), 8'd0);
        check("coin_lost", lost_cnt, 8'd0);
        check("coin_ok", 8'(clk_ok), 8'd0);
        check("coin_pll_rst", 8'(pll_reset), 8'd1);
        pll_lock = 1'b1;
        tick(14);
        check("coin_relock_run", 8'(state), 8'd3);

        // one-cycle lock glitch at STABILIZE count 5 restarts the stable count
        relock_req = 1'b1;
        tick(1);
        relock_req = 1'b0;
        check("glitch_reset", 8'(state), 8'd0);
        check("glitch_lost", lost_cnt, 8'd0);
        tick(8);
        check("glitch_stab", 8'(state), 8'd2);
        pll_lock = 1'b0;
        tick(1);
        pll_lock = 1'b1;
        tick(2);
        check("glitch_wait", 8'(state), 8'd1);
        check("glitch_ok", 8'(clk_ok), 8'd0);
        tick(1);
        check("glitch_restab", 8'(state), 8'd2);
        tick(8);
        check("glitch_count", 8'(state), 8'd2);
        check("glitch_ok2", 8'(clk_ok), 8'd0);
        tick(1);
        check("glitch_run", 8'(state), 8'd3);
        check("glitch_ok3", 8'(clk_ok), 8'd1);

        // repeated lock losses in RUN, lost_cnt saturates at 255
        exp_lost = 0;
        for (int i = 0; i < 300; i++) begin
            pll_lock = 1'b0;
            tick(2);
            check("loss_ok_hold", 8'(clk_ok), 8'd1);
            tick(1);
            check("loss_ok_fall", 8'(clk_ok), 8'd0);
            check("loss_state", 8'(state), 8'd0);
            exp_lost = (exp_lost == 255) ? 255 : exp_lost + 1;
            check("loss_cnt", lost_cnt, 8'(exp_lost));
            pll_lock = 1'b1;
            hi_cnt = 0;
            for (int j = 0; j < 14; j++) begin
                if (pll_reset) hi_cnt++;
                tick(1);
            end
            check("loss_rst_pulse", 8'(hi_cnt), 8'd4);
            check("loss_rerun", 8'(state), 8'd3);
        end

        // no lock at all: two timeouts then FAULT, relock clears it
        relock_req = 1'b1;
        pll_lock   = 1'b0;
        tick(1);
        relock_req = 1'b0;
        check("to_reset", 8'(state), 8'd0);
        check("to_lost_keep", lost_cnt, 8'd255);
        tick(4);
        check("to_wait1", 8'(state), 8'd1);
        check("to_wait1_rst", 8'(pll_reset), 8'd0);
        tick(19);
        check("to_wait1_end", 8'(state), 8'd1);
        tick(1);
        check("to_retry_reset", 8'(state), 8'd0);
        check("to_retry_rst", 8'(pll_reset), 8'd1);
        check("to_retry_fault", 8'(fault), 8'd0);
        tick(3);
        check("to_retry_hold", 8'(state), 8'd0);
        tick(1);
        check("to_wait2", 8'(state), 8'd1);
        tick(19);
        check("to_wait2_end", 8'(state), 8'd1);
        tick(1);
        check("fault_state", 8'(state), 8'd4);
        check("fault_flag", 8'(fault), 8'd1);
        check("fault_rst", 8'(pll_reset), 8'd1);
        check("fault_ok", 8'(clk_ok), 8'd0);
        tick(10);
        check("fault_held", 8'(state), 8'd4);
        check("fault_held_flag", 8'(fault), 8'd1);
        relock_req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick(1);
            check("relock_hold_state", 8'(state), 8'd0);
            check("relock_fault_clr", 8'(fault), 8'd0);
        end
        relock_req = 1'b0;
        tick(3);
        check("relock_rst_len", 8'(state), 8'd0);
        tick(1);
        check("relock_wait", 8'(state), 8'd1);
        tick(19);
        check("relock_wait_end", 8'(state), 8'd1);
        tick(1);
        check("retry_cleared", 8'(state), 8'd0);
        check("retry_no_fault", 8'(fault), 8'd0);

        // asynchronous reset in the middle of STABILIZE
        pll_lock = 1'b1;
        tick(5);
        check("async_stab", 8'(state), 8'd2);
        check("async_stab_rst", 8'(pll_reset), 8'd0);
        tick(3);
        resetn = 1'b0;
        #2;
        check("async_state", 8'(state), 8'd0);
        check("async_pll_rst", 8'(pll_reset), 8'd1);
        check("async_ok", 8'(clk_ok), 8'd0);
        check("async_fault", 8'(fault), 8'd0);
        check("async_lost", lost_cnt, 8'd0);
        tick(2);
        resetn = 1'b1;
        tick(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
